// File: rtl/data_ram_pkg.sv
// Shared definitions for the pipelined byte-lane data RAM: state encoding,
// parameter legality checks and the width helpers used by every file.
package data_ram_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int lane_count(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte lane of the data RAM: an 8-bit x DEPTH array with a synchronous
// write port and a registered read.
module data_ram_lane
    import data_ram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Kept separate from the array so the read register maps onto a block RAM output.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_pipe.sv
// MEM-stage data memory with a valid/ready request port, fixed-latency
// response channel with error flag, and an optional post-reset clear pass.
module data_ram_pipe
    import data_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [DATA_W/8-1:0] req_sel_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o
);

    localparam int LANES = lane_count(DATA_W);
    localparam int OFF_W = clog2(LANES);
    localparam int IDX_W = clog2(DEPTH);
    localparam int TOP_W = OFF_W + IDX_W;

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("data_ram_pipe: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("data_ram_pipe: DATA_W must be a multiple of 8");
    end

    state_e           state_q;
    logic [IDX_W-1:0] clrCnt_q;
    logic             busy_q;
    logic             ready_q;

    logic [IDX_W-1:0] reqIdx;
    logic             outOfRange;
    logic             reqErr;
    logic             accept;
    logic             wrEn;
    logic             rdEn;
    logic             clearing;
    logic [IDX_W-1:0] laneIdx;
    logic [DATA_W-1:0] laneRdata;

    logic              s1Valid_q;
    logic              s1Err_q;
    logic              s1Rd_q;
    logic [LANES-1:0]  s1Sel_q;
    logic [DATA_W-1:0] rspData_d;

    // Clear pass walks one word per cycle; ready and busy are registered so they
    // flip on the same edge the last word is zeroed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clrCnt_q <= '0;
            busy_q   <= (CLEAR_ON_RESET != 0);
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (clrCnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q  <= RUN;
                        clrCnt_q <= '0;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        clrCnt_q <= clrCnt_q + IDX_W'(1);
                    end
                end
                RUN: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;

    assign reqIdx     = req_addr_i[TOP_W-1:OFF_W];
    assign outOfRange = |(req_addr_i >> TOP_W);
    assign reqErr     = outOfRange | (req_sel_i == '0);
    assign accept     = req_valid_i & ready_q;
    assign wrEn       = accept & req_we_i & ~reqErr;
    assign rdEn       = accept & ~req_we_i & ~reqErr;

    if (OFF_W > 0) begin : g_offset
        logic unusedOffset;
        assign unusedOffset = ^req_addr_i[OFF_W-1:0];
    end

    assign clearing = (state_q == INIT);
    assign laneIdx  = clearing ? clrCnt_q : reqIdx;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic       laneWe;
        logic [7:0] laneWdata;

        assign laneWe    = clearing | (wrEn & req_sel_i[k]);
        assign laneWdata = clearing ? 8'h00 : req_wdata_i[8*k +: 8];

        data_ram_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk_i   (clk_i),
            .we_i    (laneWe),
            .re_i    (rdEn),
            .idx_i   (laneIdx),
            .wdata_i (laneWdata),
            .rdata_o (laneRdata[8*k +: 8])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1Valid_q <= 1'b0;
            s1Err_q   <= 1'b0;
            s1Rd_q    <= 1'b0;
            s1Sel_q   <= '0;
        end else begin
            s1Valid_q <= accept;
            s1Err_q   <= accept & reqErr;
            s1Rd_q    <= rdEn;
            s1Sel_q   <= req_sel_i;
        end
    end

    // Writes and errors return zero data; reads return only the selected lanes.
    always_comb begin
        rspData_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s1Rd_q && s1Sel_q[k]) begin
                rspData_d[8*k +: 8] = laneRdata[8*k +: 8];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2Valid_q;
        logic              s2Err_q;
        logic [DATA_W-1:0] s2Data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2Valid_q <= 1'b0;
                s2Err_q   <= 1'b0;
                s2Data_q  <= '0;
            end else begin
                s2Valid_q <= s1Valid_q;
                s2Err_q   <= s1Err_q;
                s2Data_q  <= rspData_d;
            end
        end

        assign rsp_valid_o = s2Valid_q;
        assign rsp_err_o   = s2Err_q;
        assign rsp_rdata_o = s2Data_q;
    end else begin : g_lat1
        assign rsp_valid_o = s1Valid_q;
        assign rsp_err_o   = s1Err_q;
        assign rsp_rdata_o = rspData_d;
    end

endmodule

// File: tb/tb_data_ram_pipe.sv
// Scoreboard bench for data_ram_pipe: three instances (RD_LAT=1 with clear,
// RD_LAT=2 with clear, RD_LAT=1 without clear) driven one at a time.
module tb_data_ram_pipe;

    typedef struct {
        int          inst;
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic [2:0]  rstN;
    logic [2:0]  reqValid;
    logic [2:0]  reqReady;
    logic [2:0]  reqWe;
    logic [3:0]  reqSel [3];
    logic [31:0] reqAddr [3];
    logic [31:0] reqWdata [3];
    logic [2:0]  rspValid;
    logic [31:0] rspRdata [3];
    logic [2:0]  rspErr;
    logic [2:0]  busy;

    exp_t        expQ [$];
    logic [31:0] model [3][16];
    int          cyc = 0;
    int          tests = 0;
    int          failed = 0;

    data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(1)) dutA (
        .clk_i(clk), .rst_ni(rstN[0]), .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]),
        .req_we_i(reqWe[0]), .req_sel_i(reqSel[0]), .req_addr_i(reqAddr[0]), .req_wdata_i(reqWdata[0]),
        .rsp_valid_o(rspValid[0]), .rsp_rdata_o(rspRdata[0]), .rsp_err_o(rspErr[0]), .busy_o(busy[0]));

    data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LAT(2), .CLEAR_ON_RESET(1)) dutB (
        .clk_i(clk), .rst_ni(rstN[1]), .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]),
        .req_we_i(reqWe[1]), .req_sel_i(reqSel[1]), .req_addr_i(reqAddr[1]), .req_wdata_i(reqWdata[1]),
        .rsp_valid_o(rspValid[1]), .rsp_rdata_o(rspRdata[1]), .rsp_err_o(rspErr[1]), .busy_o(busy[1]));

    data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(0)) dutC (
        .clk_i(clk), .rst_ni(rstN[2]), .req_valid_i(reqValid[2]), .req_ready_o(reqReady[2]),
        .req_we_i(reqWe[2]), .req_sel_i(reqSel[2]), .req_addr_i(reqAddr[2]), .req_wdata_i(reqWdata[2]),
        .rsp_valid_o(rspValid[2]), .rsp_rdata_o(rspRdata[2]), .rsp_err_o(rspErr[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int latOf(input int inst);
        return (inst == 1) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Every response must match the oldest expectation, including its due cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rspValid[i] === 1'b1) begin
                exp_t e;
                checkOutput($sformatf("rsp_expected_inst%0d", i),
                            32'(expQ.size() != 0 && expQ[0].inst == i), 32'd1);
                if (expQ.size() != 0 && expQ[0].inst == i) begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("rsp_cycle_inst%0d", i), 32'(cyc), 32'(e.due));
                    checkOutput($sformatf("rsp_err_inst%0d", i), 32'(rspErr[i]), 32'(e.err));
                    checkOutput($sformatf("rsp_rdata_inst%0d", i), rspRdata[i], e.data);
                end
            end
        end
    end

    task automatic clearModel(input int inst);
        for (int w = 0; w < 16; w++) model[inst][w] = 32'h0;
    endtask

    task automatic applyStimulus(input int inst, input logic we, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   word;
        checkOutput($sformatf("req_ready_inst%0d", inst), 32'(reqReady[inst]), 32'd1);
        reqValid[inst] = 1'b1;
        reqWe[inst]    = we;
        reqSel[inst]   = sel;
        reqAddr[inst]  = addr;
        reqWdata[inst] = wdata;
        word   = int'(addr[5:2]);
        e.inst = inst;
        e.due  = cyc + latOf(inst);
        e.err  = (sel == 4'b0000) || (addr >= 32'd64);
        e.data = 32'h0;
        if (!e.err) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) begin
                    if (we) model[inst][word][8*k +: 8] = wdata[8*k +: 8];
                    else    e.data[8*k +: 8] = model[inst][word][8*k +: 8];
                end
            end
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        reqValid[inst] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic countBusy(input int inst, output int n, output int readyWhileBusy);
        n = 0;
        readyWhileBusy = 0;
        @(negedge clk);
        while (busy[inst] === 1'b1 && n < 200) begin
            n++;
            if (reqReady[inst] !== 1'b0) readyWhileBusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int rw;
        rstN     = 3'b000;
        reqValid = 3'b000;
        reqWe    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            reqSel[i]   = 4'h0;
            reqAddr[i]  = 32'h0;
            reqWdata[i] = 32'h0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("A_reset_rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("A_reset_rsp_rdata", rspRdata[0], 32'h0);
        checkOutput("A_reset_rsp_err", 32'(rspErr[0]), 32'd0);
        checkOutput("A_reset_ready", 32'(reqReady[0]), 32'd0);
        checkOutput("A_reset_busy", 32'(busy[0]), 32'd1);
        checkOutput("C_reset_busy", 32'(busy[2]), 32'd0);
        checkOutput("C_reset_ready", 32'(reqReady[2]), 32'd0);

        // Instance without clear pass: ready right after the first edge, never busy.
        @(posedge clk);
        #1;
        rstN[2] = 1'b1;
        @(negedge clk);
        checkOutput("C_busy_after_release", 32'(busy[2]), 32'd0);
        @(negedge clk);
        checkOutput("C_ready_first_cycle", 32'(reqReady[2]), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(2, 1'b1, 4'b1111, 32'h10, 32'hCAFEF00D);
        applyStimulus(2, 1'b0, 4'b1111, 32'h10, 32'h0);
        drain("C_drain");
        checkOutput("C_busy_stays_low", 32'(busy[2]), 32'd0);

        // Clear sequence on both clearing instances.
        rstN[1:0] = 2'b11;
        countBusy(0, n, rw);
        checkOutput("A_clear_cycles", 32'(n), 32'd16);
        checkOutput("A_ready_during_clear", 32'(rw), 32'd0);
        checkOutput("A_ready_after_clear", 32'(reqReady[0]), 32'd1);
        checkOutput("B_busy_after_clear", 32'(busy[1]), 32'd0);
        clearModel(0);
        clearModel(1);
        @(posedge clk);
        #1;

        applyStimulus(0, 1'b0, 4'b1111, 32'h3C, 32'h0);
        applyStimulus(0, 1'b1, 4'b1111, 32'h08, 32'h11223344);
        applyStimulus(0, 1'b1, 4'b0100, 32'h08, 32'hAABBCCDD);
        applyStimulus(0, 1'b0, 4'b1111, 32'h08, 32'h0);
        applyStimulus(0, 1'b0, 4'b0011, 32'h08, 32'h0);
        applyStimulus(0, 1'b0, 4'b1111, 32'h0B, 32'h0);
        drain("A_bytes_drain");

        // Out-of-range address aliases word 0 in its index bits; it must not land there.
        applyStimulus(0, 1'b1, 4'b1111, 32'h00, 32'h01020304);
        applyStimulus(0, 1'b1, 4'b1111, 32'h40, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, 4'b1111, 32'h00, 32'h0);
        applyStimulus(0, 1'b0, 4'b0000, 32'h00, 32'h0);
        applyStimulus(0, 1'b0, 4'b1111, 32'h1000_0000, 32'h0);
        drain("A_err_drain");

        applyStimulus(1, 1'b1, 4'b1111, 32'h14, 32'hA5A50005);
        applyStimulus(1, 1'b0, 4'b1111, 32'h14, 32'h0);
        applyStimulus(1, 1'b1, 4'b1111, 32'h18, 32'h0BADBEEF);
        applyStimulus(1, 1'b0, 4'b1111, 32'h18, 32'h0);
        applyStimulus(1, 1'b0, 4'b1000, 32'h14, 32'h0);
        applyStimulus(1, 1'b1, 4'b0001, 32'h1C, 32'h123456CC);
        applyStimulus(1, 1'b0, 4'b1111, 32'h1C, 32'h0);
        applyStimulus(1, 1'b1, 4'b1111, 32'h80, 32'h0);
        drain("B_b2b_drain");

        // Two reads in flight when reset hits: their responses must never appear.
        applyStimulus(1, 1'b0, 4'b1111, 32'h14, 32'h0);
        applyStimulus(1, 1'b0, 4'b1111, 32'h18, 32'h0);
        rstN[1] = 1'b0;
        expQ.delete();
        #1;
        checkOutput("B_busy_in_reset", 32'(busy[1]), 32'd1);
        checkOutput("B_ready_in_reset", 32'(reqReady[1]), 32'd0);
        @(posedge clk);
        #1;
        rstN[1] = 1'b1;
        countBusy(1, n, rw);
        checkOutput("B_reclear_cycles", 32'(n), 32'd16);
        checkOutput("B_ready_during_reclear", 32'(rw), 32'd0);
        clearModel(1);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 4'b1111, 32'h14, 32'h0);
        applyStimulus(1, 1'b0, 4'b1111, 32'h18, 32'h0);
        drain("B_reset_drain");

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
